// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types and constants for the FIFO read-side streamer.
//   state_t   : read-control FSM states (PAUSE, RUN, FLUSH), 2-bit encoding.
//   SKID_MIN  : smallest legal skid-buffer depth.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int unsigned SKID_MIN = 2;

endpackage : fifo_rd_pkg

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: bundles the FIFO read port and the outgoing valid/ready
// stream of fifo_rd_stream.
//   fifo_empty  FIFO empty flag (read domain, combinational)
//   fifo_rdata  FIFO read data, valid the cycle after an accepted read
//   fifo_rd     FIFO read strobe
//   m_valid     output beat valid
//   m_ready     downstream ready
//   m_data      output beat data
// Modports: master = the streamer, slave = FIFO + downstream side.
interface fifo_rd_stream_if #(
  parameter int FW = 8
);
  logic          fifo_empty;
  logic [FW-1:0] fifo_rdata;
  logic          fifo_rd;
  logic          m_valid;
  logic          m_ready;
  logic [FW-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_rdata, m_ready,
    output fifo_rd, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_rdata, m_ready,
    input  fifo_rd, m_valid, m_data
  );
endinterface : fifo_rd_stream_if

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: SKID-entry circular buffer holding words captured from the
// FIFO until the downstream stream accepts them.
//   clk, rst_n  clock, asynchronous active-low reset
//   push/wdata  write wdata at the tail
//   pop         advance the head (caller guarantees cnt != 0)
//   clear       drop all contents, reset pointers (wins over push/pop)
//   cnt         current occupancy, 0..SKID
//   head_data   word at the head, read straight from the storage register
module fifo_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter  int FW   = 8,
  parameter  int SKID = 3,
  localparam int CW   = $clog2(SKID + 1),
  localparam int PW   = $clog2(SKID)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [FW-1:0] wdata,
  output logic [CW-1:0] cnt,
  output logic [FW-1:0] head_data
);

  if (SKID < int'(SKID_MIN)) begin : g_skid_check
    $error("fifo_skid_buf: SKID below minimum depth");
  end

  logic [FW-1:0] mem [SKID];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  // Pointers wrap modulo SKID, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int unsigned i = 0; i < SKID; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[tail] <= wdata;
        tail      <= ptr_inc(tail);
      end
      if (pop) begin
        head <= ptr_inc(head);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_data = mem[head];

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= CW'(SKID));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !pop && !clear) |-> (cnt < CW'(SKID)));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    (pop && !clear) |-> (cnt != '0));

endmodule : fifo_skid_buf

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-domain consumer of the dual-clock FIFO. Issues FIFO
// reads, captures the data one cycle later into a skid buffer and presents
// it as a valid/ready stream. Supports run/pause (en) and a flush mode that
// discards buffered and in-flight data and drains the FIFO.
//   r_clk     read-domain clock
//   rst_n     asynchronous active-low reset
//   en        1 = issue FIFO reads, 0 = pause reads (buffer still drains)
//   flush     single-cycle pulse: discard and drain
//   bus       fifo_rd_stream_if.master (FIFO read port + output stream)
//   busy      high in FLUSH or while a read is in flight
// Optional: define FIFO_RD_STATS_EN to add 32-bit beat_cnt (stream transfers)
// and drop_cnt (words discarded by flush) outputs.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int FW   = 8,
  parameter int SKID = 3
) (
  input  logic                     r_clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     flush,
  fifo_rd_stream_if.master         bus,
  output logic                     busy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]              beat_cnt,
  output logic [31:0]              drop_cnt
`endif
);

  localparam int CW = $clog2(SKID + 1);

  state_t        state;
  state_t        state_nxt;
  logic          inflight;
  logic          rd;
  logic          room;
  logic          push;
  logic          pop;
  logic          valid;
  logic [CW-1:0] cnt;
  logic [FW-1:0] head_data;

  // Read gating uses only registered occupancy plus the FIFO flag, so there
  // is no combinational path from m_ready to fifo_rd.
  assign room = ({1'b0, cnt} + {{CW{1'b0}}, inflight}) < (CW + 1)'(SKID);

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PAUSE;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= rd;
    end
  end

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    case (state)
      PAUSE: begin
        if (en) state_nxt = RUN;
      end
      RUN: begin
        rd = !bus.fifo_empty && room;
        if (!en) state_nxt = PAUSE;
      end
      FLUSH: begin
        rd = !bus.fifo_empty;
        if (bus.fifo_empty && !inflight) state_nxt = en ? RUN : PAUSE;
      end
      default: state_nxt = PAUSE;
    endcase
    if (flush) state_nxt = FLUSH;
  end

  // A word landing on the flush edge or during FLUSH is discarded.
  assign push  = inflight && (state != FLUSH) && !flush;
  assign valid = (cnt != '0) && (state != FLUSH);
  assign pop   = valid && bus.m_ready;

  fifo_skid_buf #(
    .FW   (FW),
    .SKID (SKID)
  ) u_buf (
    .clk       (r_clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .clear     (flush),
    .wdata     (bus.fifo_rdata),
    .cnt       (cnt),
    .head_data (head_data)
  );

  assign bus.fifo_rd = rd;
  assign bus.m_valid = valid;
  assign bus.m_data  = head_data;
  assign busy        = (state == FLUSH) || inflight;

`ifdef FIFO_RD_STATS_EN
  logic [31:0] drop_inc;

  // Flush drops whatever is buffered except a beat leaving that same cycle,
  // plus any word captured on the flush edge or read while in FLUSH.
  assign drop_inc = (flush ? (32'(cnt) - 32'(pop)) : 32'd0)
                  + 32'(inflight && (flush || (state == FLUSH)));

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      beat_cnt <= beat_cnt + 32'(pop);
      drop_cnt <= drop_cnt + drop_inc;
    end
  end
`endif

  a_no_rd_when_empty: assert property (@(posedge r_clk) disable iff (!rst_n)
    bus.fifo_rd |-> !bus.fifo_empty);

endmodule : fifo_rd_stream
